// File: rtl/prio_scan_encoder.sv
// rtl/prio_scan_encoder.sv - MSB-first sequential priority scan encoder; optional PRIO_SCAN_COUNT_EN adds a remaining count
module prio_scan_encoder #(
  parameter int  WIDTH      = 8,
  parameter bit  ACTIVE_LOW = 1'b1,
  localparam int IDX_W      = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] req_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [IDX_W:0]   out_code,
  output logic             busy,
  output logic             done
`ifdef PRIO_SCAN_COUNT_EN
  ,
  output logic [IDX_W:0]   remaining
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic [WIDTH-1:0] nreq;
  logic [WIDTH-1:0] sel_mask;
  logic [IDX_W-1:0] hi_idx;
  logic             done_q, done_d;
  logic             xfer;

  // Legacy encoders used active-low request lines; fold polarity in once here.
  assign nreq = ACTIVE_LOW ? ~req_in : req_in;

  // Highest set bit of the registered pending vector; later (higher) bits win.
  always_comb begin
    hi_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (pending_q[i]) hi_idx = IDX_W'(i);
    end
  end

  // One-hot mask of the bit being handed out, used to retire it on transfer.
  always_comb begin
    sel_mask         = '0;
    sel_mask[hi_idx] = 1'b1;
  end

  assign out_valid = (state_q == SCAN);
  assign busy      = (state_q == SCAN);
  assign out_idx   = out_valid ? hi_idx : '0;
  assign out_code  = out_valid ? {1'b1, hi_idx} : '0;
  assign done      = done_q;
  assign xfer      = out_valid & out_ready;

  // State register: pending bits, scan state and the registered done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      done_q    <= done_d;
    end
  end

  // Next state: capture in IDLE, retire one bit per accepted index in SCAN.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          pending_d = nreq;
          if (nreq != '0) state_d = SCAN;
          else            done_d  = 1'b1;
        end
      end
      SCAN: begin
        if (out_ready) begin
          pending_d = pending_q & ~sel_mask;
          if ((pending_q & ~sel_mask) == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        pending_d = '0;
      end
    endcase
  end

`ifdef PRIO_SCAN_COUNT_EN
  logic [IDX_W:0] remaining_q;

  function automatic logic [IDX_W:0] popcount(input logic [WIDTH-1:0] v);
    logic [IDX_W:0] cnt;
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) cnt = cnt + (IDX_W+1)'(v[i]);
    return cnt;
  endfunction

  // Count of requests still to be emitted; tracks pending without a popcount on the output path.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      remaining_q <= '0;
    end else if ((state_q == IDLE) && load) begin
      remaining_q <= popcount(nreq);
    end else if (xfer) begin
      remaining_q <= remaining_q - 1'b1;
    end
  end

  assign remaining = remaining_q;
`endif

endmodule

// File: tb/tb_prio_scan_encoder.sv
// tb/tb_prio_scan_encoder.sv - scoreboard bench for prio_scan_encoder
module tb_prio_scan_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       load8, ready8;
  logic [7:0] req8;
  logic       valid8, busy8, done8;
  logic [2:0] idx8;
  logic [3:0] code8;

  logic        load16, ready16;
  logic [15:0] req16;
  logic        valid16, busy16, done16;
  logic [3:0]  idx16;
  logic [4:0]  code16;

`ifdef PRIO_SCAN_COUNT_EN
  logic [3:0] rem8;
  logic [4:0] rem16;
`endif

  int checks   = 0;
  int failures = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  prio_scan_encoder #(.WIDTH(8), .ACTIVE_LOW(1'b1)) dut8 (
    .clk(clk), .reset(rst), .load(load8), .req_in(req8),
    .out_valid(valid8), .out_ready(ready8), .out_idx(idx8),
    .out_code(code8), .busy(busy8), .done(done8)
`ifdef PRIO_SCAN_COUNT_EN
    , .remaining(rem8)
`endif
  );

  prio_scan_encoder #(.WIDTH(16), .ACTIVE_LOW(1'b0)) dut16 (
    .clk(clk), .reset(rst), .load(load16), .req_in(req16),
    .out_valid(valid16), .out_ready(ready16), .out_idx(idx16),
    .out_code(code16), .busy(busy16), .done(done16)
`ifdef PRIO_SCAN_COUNT_EN
    , .remaining(rem16)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [7:0] r);
    load8 = 1'b1;
    req8  = r;
    step();
    load8 = 1'b0;
    req8  = 8'h00;
  endtask

  // Drain the scoreboard with out_ready high, then expect a single done pulse.
  task automatic drain8(input string tag);
    int e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_valid"}, 32'(valid8), 32'd1);
      chk({tag, "_busy"}, 32'(busy8), 32'd1);
      chk({tag, "_idx"}, 32'(idx8), 32'(e));
      chk({tag, "_code"}, 32'(code8), 32'(8 + e));
      chk({tag, "_nodone"}, 32'(done8), 32'd0);
      step();
    end
    chk({tag, "_done"}, 32'(done8), 32'd1);
    chk({tag, "_idle_valid"}, 32'(valid8), 32'd0);
    chk({tag, "_idle_code"}, 32'(code8), 32'd0);
`ifdef PRIO_SCAN_COUNT_EN
    chk({tag, "_rem_done"}, 32'(rem8), 32'd0);
`endif
    step();
    chk({tag, "_done_once"}, 32'(done8), 32'd0);
  endtask

  initial begin
    rst    = 1'b1;
    load8  = 1'b0; req8  = 8'h00;  ready8  = 1'b1;
    load16 = 1'b0; req16 = 16'h0;  ready16 = 1'b1;
    #12;
    chk("rst_valid", 32'(valid8), 32'd0);
    chk("rst_idx", 32'(idx8), 32'd0);
    chk("rst_code", 32'(code8), 32'd0);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    rst = 1'b0;
    step();

    // 1: active-low 01001000 -> 7,5,4,2,1,0
    exp_q = '{7, 5, 4, 2, 1, 0};
    load_word(8'b01001000);
`ifdef PRIO_SCAN_COUNT_EN
    chk("t1_rem", 32'(rem8), 32'd6);
`endif
    drain8("t1");

    // 2: all inactive -> immediate done, never valid
    load_word(8'b11111111);
    chk("t2_valid", 32'(valid8), 32'd0);
    chk("t2_code", 32'(code8), 32'd0);
    chk("t2_busy", 32'(busy8), 32'd0);
    chk("t2_done", 32'(done8), 32'd1);
    step();
    chk("t2_done_once", 32'(done8), 32'd0);
    chk("t2_valid2", 32'(valid8), 32'd0);

    // 3: backpressure holds index 6
    ready8 = 1'b0;
    load_word(8'b10001000);
    for (int i = 0; i < 3; i++) begin
      chk("t3_hold_valid", 32'(valid8), 32'd1);
      chk("t3_hold_idx", 32'(idx8), 32'd6);
      chk("t3_hold_code", 32'(code8), 32'hE);
      step();
    end
    ready8 = 1'b1;
    exp_q = '{6, 5, 4, 2, 1, 0};
    drain8("t3");

    // 4: a load during the scan is ignored
    load_word(8'b11001000);
    chk("t4_first_idx", 32'(idx8), 32'd5);
    load8 = 1'b1;
    req8  = 8'b00000000;
    step();
    load8 = 1'b0;
    exp_q = '{4, 2, 1, 0};
    drain8("t4");

    // 5: reset mid-scan, then a fresh load
    load_word(8'b11101000);
    chk("t5_idx_a", 32'(idx8), 32'd4);
    step();
    chk("t5_idx_b", 32'(idx8), 32'd2);
    step();
    chk("t5_idx_c", 32'(idx8), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("t5_rst_valid", 32'(valid8), 32'd0);
    chk("t5_rst_idx", 32'(idx8), 32'd0);
    chk("t5_rst_code", 32'(code8), 32'd0);
    chk("t5_rst_busy", 32'(busy8), 32'd0);
    #1 rst = 1'b0;
    step();
    chk("t5_no_done", 32'(done8), 32'd0);
    chk("t5_idle", 32'(valid8), 32'd0);
    exp_q = '{2, 1, 0};
    load_word(8'b11111000);
    drain8("t5");

    // 6: WIDTH=16 active-high 8001 -> 15 then 0
    load16 = 1'b1;
    req16  = 16'h8001;
    step();
    load16 = 1'b0;
    req16  = 16'h0;
    chk("t6_valid_a", 32'(valid16), 32'd1);
    chk("t6_idx_a", 32'(idx16), 32'd15);
    chk("t6_code_a", 32'(code16), 32'h1F);
`ifdef PRIO_SCAN_COUNT_EN
    chk("t6_rem_a", 32'(rem16), 32'd2);
`endif
    step();
    chk("t6_idx_b", 32'(idx16), 32'd0);
    chk("t6_code_b", 32'(code16), 32'h10);
    chk("t6_nodone", 32'(done16), 32'd0);
`ifdef PRIO_SCAN_COUNT_EN
    chk("t6_rem_b", 32'(rem16), 32'd1);
`endif
    step();
    chk("t6_done", 32'(done16), 32'd1);
    chk("t6_valid_end", 32'(valid16), 32'd0);
    chk("t6_code_end", 32'(code16), 32'd0);
`ifdef PRIO_SCAN_COUNT_EN
    chk("t6_rem_c", 32'(rem16), 32'd0);
`endif
    step();
    chk("t6_done_once", 32'(done16), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
